esc_commutator: RTL
===================

Name: esc_commutator

Overview:
Parametrised six-step commutation sequencer for a 3-coil BLDC ESC. It replaces the fixed-rate, forward-only coil sequencer with the following: an alignment phase, a programmable step period with a linear slew toward a target speed, direction control, and a PWM duty gate on the energised coils. It runs on the system clock with no derived clocks and drives the coil outputs directly.

Parameters:
PERIOD_W, 16, width of the step-period counter and of target_period
START_PERIOD, 50000, step period in clk cycles at spin-up and the slowest legal period; must be <= 2^PERIOD_W-1
MIN_PERIOD, 500, fastest legal step period in clk cycles; must be >= 2 and <= START_PERIOD
RAMP_STEP, 250, maximum change of the period per commutation, in clk cycles; must be >= 1
ALIGN_CYCLES, 100000, clk cycles spent holding step 0 before spinning; must be >= 1
PWM_W, 8, width of the duty input and of the PWM counter

Ports:
clk  in  1  system clock
_rst  in  1  asynchronous active-low reset
enable  in  1  run request, level-sensitive
dir  in  1  1 = forward (index increments), 0 = reverse; latched on start
target_period  in  PERIOD_W  requested step period in clk cycles
duty  in  PWM_W  PWM on-time; 0 = off, all-ones = fully on
bobina_A  out  1  coil A drive
bobina_B  out  1  coil B drive
bobina_C  out  1  coil C drive
step_idx  out  3  current commutation index, 0..5
running  out  1  high in ALIGN and SPIN
at_speed  out  1  high in SPIN when cur_period equals the clamped target

Behaviour:
- Reset (async, _rst low): state IDLE, step_idx 0, cur_period START_PERIOD, step_cnt 0, pwm_cnt 0, latched dir 1. All outputs are 0 while reset is held and in the cycle after release.
- Step patterns {A,B,C} by index:
  - 0: 110
  - 1: 100
  - 2: 101
  - 3: 001
  - 4: 011
  - 5: 010
- Coil outputs (registered, one-cycle latency from state/index/pwm): coils = pattern[step_idx] AND pwm_on in ALIGN and SPIN, and 000 in IDLE.
- PWM:
  - pwm_cnt is a free-running PWM_W-bit counter that wraps.
  - pwm_on = (pwm_cnt < duty) OR (duty == all-ones).
- Clamped target: tgt_c = MIN_PERIOD if target_period < MIN_PERIOD; START_PERIOD if target_period > START_PERIOD; otherwise target_period. Evaluated every cycle.
- FSM:
  - IDLE: when enable=1, latch dir, set step_idx 0 and step_cnt 0, and go to ALIGN next cycle.
  - ALIGN: step_idx is held at 0. After step_cnt counts ALIGN_CYCLES cycles, go to SPIN with step_cnt 0 and cur_period START_PERIOD.
  - SPIN:
    - step_cnt increments each cycle.
    - When step_cnt == cur_period-1, commutate in that same cycle: step_idx advances (forward 5->0, reverse 0->5), step_cnt returns to 0, and cur_period slews.
    - Slew: if cur_period > tgt_c, cur_period = max(cur_period-RAMP_STEP, tgt_c); if cur_period < tgt_c, cur_period = min(cur_period+RAMP_STEP, tgt_c).
    - The slew arithmetic is computed at PERIOD_W+1 bits so it cannot underflow or overflow.
  - enable=0 in ALIGN or SPIN: go to IDLE next cycle and set step_idx 0; takes priority over a coincident commutation.
- dir changes while running are ignored until the next IDLE->ALIGN transition.
- target_period changes take effect only at commutation boundaries, through the slew.
- at_speed: registered; updated with cur_period; cleared outside SPIN.

Optional Feature:
ESC_BRAKE_EN
- Defined: enable=0 while in SPIN goes to state BRAKE instead of IDLE.
  - BRAKE drives coils 111, not PWM-gated, for START_PERIOD cycles, then goes to IDLE.
  - running=0 in BRAKE.
  - enable=1 during BRAKE is ignored until IDLE is reached.
  - enable=0 in ALIGN still goes directly to IDLE.
- Undefined: the BRAKE state does not exist; behaviour is exactly as described above.

Decomposition:
- Package esc_pkg:
  - state enum (IDLE, ALIGN, SPIN, BRAKE under macro)
  - step_idx_t (3-bit)
  - 6-entry constant coil-pattern array
  - index next/prev helper functions
- Sub-module esc_pwm (params PWM_W; ports clk, _rst, duty, pwm_on) holds the PWM counter and compare.

Test Plan:
All scenarios use PERIOD_W=8, START_PERIOD=40, MIN_PERIOD=8, RAMP_STEP=4, ALIGN_CYCLES=16, PWM_W=4, duty=15 unless stated.
1. Spin-up: enable=1, dir=1, target=8 -> coils 110 for 16 cycles, then step periods 40,36,...,12 followed by 8 thereafter; step_idx 0,1,2,3,4,5,0; at_speed rises at the 8th commutation.
2. Reverse: dir=0 at start -> step_idx 0,5,4,3 with coils 110,010,011,001; dir toggled mid-SPIN causes no change.
3. PWM: duty=8 in ALIGN -> coils 110 for 8 of every 16 cycles; duty=0 -> coils 000 while step_idx still sequences.
4. Clamp/slew: at_speed with target=8, then target=200 -> periods grow 12,16,...,40 and stop at 40, at_speed re-asserts; target=2 -> settles at 8.
5. Abort: enable=0 mid-SPIN -> next cycle IDLE, coils 000, step_idx 0, running 0; _rst pulse mid-step -> all outputs 0 immediately.
6. ESC_BRAKE_EN: enable=0 in SPIN -> coils 111 for 40 cycles, then 000/IDLE; enable=1 during BRAKE is ignored.

Source files
------------

// File: rtl/esc_pkg.sv
// Shared types and helpers for the six-step BLDC commutation sequencer.
// The BRAKE state exists only when ESC_BRAKE_EN is defined.
package esc_pkg;

  typedef logic [2:0] step_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_SPIN  = 2'd2
`ifdef ESC_BRAKE_EN
    ,
    ST_BRAKE = 2'd3
`endif
  } state_e;

  // {A,B,C} drive per commutation index; entry 0 is the rightmost element
  localparam logic [5:0][2:0] COIL_PAT = {
    3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110
  };

  function automatic logic [2:0] coil_pattern(input step_idx_t idx);
    return (idx < step_idx_t'(6)) ? COIL_PAT[idx] : 3'b000;
  endfunction

  function automatic step_idx_t idx_next(input step_idx_t idx);
    return (idx == step_idx_t'(5)) ? step_idx_t'(0) : idx + step_idx_t'(1);
  endfunction

  function automatic step_idx_t idx_prev(input step_idx_t idx);
    return (idx == step_idx_t'(0)) ? step_idx_t'(5) : idx - step_idx_t'(1);
  endfunction

endpackage

// File: rtl/esc_pwm.sv
// Free-running PWM counter with duty compare; all-ones duty forces the output on.
module esc_pwm #(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_on
);

  logic [PWM_W-1:0] r_pwm_cnt;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  assign pwm_on = (r_pwm_cnt < duty) || (duty == {PWM_W{1'b1}});

endmodule

// File: rtl/esc_commutator.sv
// Six-step BLDC commutation sequencer: align, ramped spin, direction and PWM gating.
// Optional ESC_BRAKE_EN adds a timed all-coils-on brake when spin is aborted.
module esc_commutator
  import esc_pkg::*;
#(
  parameter int unsigned PERIOD_W     = 16,
  parameter int unsigned START_PERIOD = 50000,
  parameter int unsigned MIN_PERIOD   = 500,
  parameter int unsigned RAMP_STEP    = 250,
  parameter int unsigned ALIGN_CYCLES = 100000,
  parameter int unsigned PWM_W        = 8
) (
  input  logic                clk,
  input  logic                _rst,
  input  logic                enable,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] target_period,
  input  logic [PWM_W-1:0]    duty,
  output logic                bobina_A,
  output logic                bobina_B,
  output logic                bobina_C,
  output logic [2:0]          step_idx,
  output logic                running,
  output logic                at_speed
);

  // Shared counter must span both the alignment hold and the longest step
  localparam int unsigned ALIGN_W = (ALIGN_CYCLES > 1) ? $clog2(ALIGN_CYCLES) : 1;
  localparam int unsigned CNT_W   = (ALIGN_W > PERIOD_W) ? ALIGN_W : PERIOD_W;
  localparam int unsigned SLEW_W  = PERIOD_W + 1;

  state_e              r_state,      w_state_n;
  step_idx_t           r_step_idx,   w_step_idx_n;
  logic [PERIOD_W-1:0] r_cur_period, w_cur_period_n;
  logic [CNT_W-1:0]    r_step_cnt,   w_step_cnt_n;
  logic                r_dir,        w_dir_n;
  logic [2:0]          r_coils,      w_coils_n;
  logic                r_running,    w_running_n;
  logic                r_at_speed,   w_at_speed_n;

  logic                w_pwm_on;
  logic [PERIOD_W-1:0] w_tgt_c;
  logic [SLEW_W-1:0]   w_cur_ext, w_tgt_ext, w_ramp_ext, w_inc, w_slew;
  logic                w_last_step;

  esc_pwm #(
    .PWM_W (PWM_W)
  ) u_pwm (
    .clk    (clk),
    ._rst   (_rst),
    .duty   (duty),
    .pwm_on (w_pwm_on)
  );

  // Target clamped into the legal period window
  always_comb begin
    if (target_period < PERIOD_W'(MIN_PERIOD)) begin
      w_tgt_c = PERIOD_W'(MIN_PERIOD);
    end else if (target_period > PERIOD_W'(START_PERIOD)) begin
      w_tgt_c = PERIOD_W'(START_PERIOD);
    end else begin
      w_tgt_c = target_period;
    end
  end

  // One bit of headroom keeps both ramp directions free of wrap-around
  assign w_cur_ext  = SLEW_W'(r_cur_period);
  assign w_tgt_ext  = SLEW_W'(w_tgt_c);
  assign w_ramp_ext = SLEW_W'(RAMP_STEP);
  assign w_inc      = w_cur_ext + w_ramp_ext;

  always_comb begin
    if (w_cur_ext > w_tgt_ext) begin
      w_slew = (w_cur_ext > w_tgt_ext + w_ramp_ext) ? w_cur_ext - w_ramp_ext : w_tgt_ext;
    end else begin
      w_slew = (w_inc < w_tgt_ext) ? w_inc : w_tgt_ext;
    end
  end

  assign w_last_step = (r_step_cnt == CNT_W'(r_cur_period - PERIOD_W'(1)));

  always_comb begin
    w_state_n      = r_state;
    w_step_idx_n   = r_step_idx;
    w_cur_period_n = r_cur_period;
    w_step_cnt_n   = r_step_cnt + CNT_W'(1);
    w_dir_n        = r_dir;
    w_coils_n      = 3'b000;
    case (r_state)
      ST_IDLE: begin
        w_step_cnt_n = '0;
        if (enable) begin
          w_state_n    = ST_ALIGN;
          w_dir_n      = dir;
          w_step_idx_n = '0;
        end
      end
      ST_ALIGN: begin
        w_coils_n    = coil_pattern(r_step_idx) & {3{w_pwm_on}};
        w_step_idx_n = '0;
        if (!enable) begin
          w_state_n    = ST_IDLE;
          w_step_cnt_n = '0;
        end else if (r_step_cnt == CNT_W'(ALIGN_CYCLES - 1)) begin
          w_state_n      = ST_SPIN;
          w_step_cnt_n   = '0;
          w_cur_period_n = PERIOD_W'(START_PERIOD);
        end
      end
      ST_SPIN: begin
        w_coils_n = coil_pattern(r_step_idx) & {3{w_pwm_on}};
        if (!enable) begin
`ifdef ESC_BRAKE_EN
          w_state_n = ST_BRAKE;
`else
          w_state_n = ST_IDLE;
`endif
          w_step_idx_n = '0;
          w_step_cnt_n = '0;
        end else if (w_last_step) begin
          w_step_idx_n   = r_dir ? idx_next(r_step_idx) : idx_prev(r_step_idx);
          w_step_cnt_n   = '0;
          w_cur_period_n = PERIOD_W'(w_slew);
        end
      end
`ifdef ESC_BRAKE_EN
      ST_BRAKE: begin
        w_coils_n = 3'b111;
        if (r_step_cnt == CNT_W'(START_PERIOD - 1)) begin
          w_state_n    = ST_IDLE;
          w_step_cnt_n = '0;
        end
      end
`endif
      default: begin
        w_state_n    = ST_IDLE;
        w_step_idx_n = '0;
        w_step_cnt_n = '0;
      end
    endcase
    w_running_n  = (w_state_n == ST_ALIGN) || (w_state_n == ST_SPIN);
    w_at_speed_n = (w_state_n == ST_SPIN) && (w_cur_period_n == w_tgt_c);
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state      <= ST_IDLE;
      r_step_idx   <= '0;
      r_cur_period <= PERIOD_W'(START_PERIOD);
      r_step_cnt   <= '0;
      r_dir        <= 1'b1;
      r_coils      <= 3'b000;
      r_running    <= 1'b0;
      r_at_speed   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_step_idx   <= w_step_idx_n;
      r_cur_period <= w_cur_period_n;
      r_step_cnt   <= w_step_cnt_n;
      r_dir        <= w_dir_n;
      r_coils      <= w_coils_n;
      r_running    <= w_running_n;
      r_at_speed   <= w_at_speed_n;
    end
  end

  assign {bobina_A, bobina_B, bobina_C} = r_coils;
  assign step_idx = r_step_idx;
  assign running  = r_running;
  assign at_speed = r_at_speed;

endmodule
